// File: rtl/wilkinson_stream_splitter.sv
// One input stream broadcast to NOUT ports, each behind its own FIFO so a slow consumer only
// blocks the source once its FIFO is full. Define SPLIT_STATS_EN to add per-port stall counters.
module wilkinson_stream_splitter #(
    parameter int WIDTH = 16,
    parameter int NOUT  = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NOUT*WIDTH-1:0]  out_data,
    output logic [NOUT-1:0]        out_valid,
    input  logic [NOUT-1:0]        out_ready,
    output logic [NOUT*LVL_W-1:0]  out_level
`ifdef SPLIT_STATS_EN
    ,
    output logic [NOUT*CNT_W-1:0]  stall_cnt
`endif
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [NOUT-1:0]  full;
    logic             push;

    // Every FIFO is written together, so a single write pointer serves all ports.
    assign in_ready = !rst && !(|full);
    assign push     = in_valid && in_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_ptr_q <= '0;
        else     wr_ptr_q <= wr_ptr_d;
    end

    for (genvar i = 0; i < NOUT; i++) begin : g_port
        logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
        logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
        logic [LVL_W-1:0]            level_q, level_d;
        logic                        pop;

        assign full[i]                      = (level_q == LVL_W'(DEPTH));
        assign out_valid[i]                 = (level_q != '0);
        assign pop                          = out_valid[i] && out_ready[i];
        assign out_data[i*WIDTH +: WIDTH]   = out_valid[i] ? mem_q[rd_ptr_q] : '0;
        assign out_level[i*LVL_W +: LVL_W]  = level_q;

        always_comb begin
            mem_d    = mem_q;
            rd_ptr_d = rd_ptr_q;
            level_d  = level_q;
            if (push) mem_d[wr_ptr_q] = in_data;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q    <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                mem_q    <= mem_d;
                rd_ptr_q <= rd_ptr_d;
                level_q  <= level_d;
            end
        end

`ifdef SPLIT_STATS_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Counts source cycles blocked by this port; saturates instead of wrapping.
        always_comb begin
            cnt_d = cnt_q;
            if (in_valid && full[i] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign stall_cnt[i*CNT_W +: CNT_W] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_wilkinson_stream_splitter.sv
// Scoreboard bench for wilkinson_stream_splitter (NOUT=2, DEPTH=4); stall counters are checked
// when SPLIT_STATS_EN is defined.
module tb_wilkinson_stream_splitter;
    localparam int WIDTH = 16;
    localparam int NOUT  = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOUT*WIDTH-1:0] out_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;
    logic [NOUT*LVL_W-1:0] out_level;
`ifdef SPLIT_STATS_EN
    logic [NOUT*CNT_W-1:0] stall_cnt;
`endif

    wilkinson_stream_splitter #(.WIDTH(WIDTH), .NOUT(NOUT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level)
`ifdef SPLIT_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [WIDTH-1:0] exp_q [NOUT][$];
    int         pops [NOUT];
    logic       acc;
    logic       slow = 1'b0;
    int         cyc  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs already set: record handshakes of the coming edge.
    task automatic tick();
        logic [WIDTH-1:0] e;
        if (slow) out_ready = cyc[0] ? 2'b00 : 2'b11;
        cyc++;
        acc = in_valid && in_ready;
        for (int p = 0; p < NOUT; p++) begin
            if (acc) exp_q[p].push_back(in_data);
            if (out_valid[p] && out_ready[p]) begin
                if (exp_q[p].size() == 0) begin
                    chk($sformatf("extra_out%0d", p), 32'(out_data[p*WIDTH +: WIDTH]), 32'hdead);
                end else begin
                    e = exp_q[p].pop_front();
                    chk($sformatf("data%0d", p), 32'(out_data[p*WIDTH +: WIDTH]), 32'(e));
                    pops[p]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        int n = 0;
        in_data  = v;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        if (!slow) out_ready = '1;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty0", 32'(exp_q[0].size()), 32'd0);
        chk("drain_empty1", 32'(exp_q[1].size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [LVL_W-1:0] lvl(input int p);
        return out_level[p*LVL_W +: LVL_W];
    endfunction

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = '0;
        pops[0] = 0; pops[1] = 0;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_level", 32'(out_level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Broadcast with one-cycle latency, then a gapless 100-sample stream
        out_ready = 2'b11;
        in_data = 16'h1234; in_valid = 1'b1;
        tick();
        chk("bcast_valid", 32'(out_valid), 32'd3);
        chk("bcast_data0", 32'(out_data[15:0]), 32'h1234);
        chk("bcast_data1", 32'(out_data[31:16]), 32'h1234);
        for (int k = 0; k < 100; k++) begin
            in_data = 16'(16'h0100 + k);
            chk("stream_ready", 32'(in_ready), 32'd1);
            chk("stream_nogap", 32'(out_valid), 32'd3);
            tick();
        end
        drain();

        // Isolation: port 1 stalled, port 0 keeps flowing until the source blocks
        pops[0] = 0; pops[1] = 0;
        out_ready = 2'b01;
        for (int k = 1; k <= 4; k++) send(16'(k));
        chk("iso_level1", 32'(lvl(1)), 32'd4);
        in_data = 16'd5; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("iso_blocked", 32'(in_ready), 32'd0);
            tick();
        end
        chk("iso_port0_took", 32'(pops[0]), 32'd4);
        chk("iso_port1_took", 32'(pops[1]), 32'd0);
`ifdef SPLIT_STATS_EN
        chk("iso_stall1", 32'(stall_cnt[CNT_W +: CNT_W]), 32'd5);
        chk("iso_stall0", 32'(stall_cnt[0 +: CNT_W]), 32'd0);
`endif
        out_ready = 2'b11;
        send(16'd5);
        send(16'd6);
        drain();

        // Full boundary: push+pop at level 3, and pop from level 4
        out_ready = 2'b00;
        for (int k = 0; k < 3; k++) send(16'(16'h0200 + k));
        chk("fb_level3_0", 32'(lvl(0)), 32'd3);
        out_ready = 2'b11;
        send(16'h0210);
        chk("fb_pushpop_0", 32'(lvl(0)), 32'd3);
        chk("fb_pushpop_1", 32'(lvl(1)), 32'd3);
        out_ready = 2'b00;
        send(16'h0211);
        chk("fb_level4", 32'(lvl(1)), 32'd4);
        chk("fb_full_ready", 32'(in_ready), 32'd0);
        out_ready = 2'b11;
        tick();
        chk("fb_pop_level", 32'(lvl(0)), 32'd3);
        chk("fb_pop_ready", 32'(in_ready), 32'd1);
        drain();

        // Pointer wrap through a slow consumer
        slow = 1'b1;
        for (int k = 0; k < 3*DEPTH + 1; k++) send(16'(16'h0300 + k));
        drain();
        slow = 1'b0;
        out_ready = 2'b00;

        // Async reset mid-stream discards buffered samples
        for (int k = 0; k < 3; k++) send(16'(16'h0400 + k));
        chk("mid_level3", 32'(lvl(0)), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_level", 32'(out_level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        exp_q[0].delete(); exp_q[1].delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            chk("post_mid_valid", 32'(out_valid), 32'd0);
            tick();
        end

`ifdef SPLIT_STATS_EN
        // Saturation of a 4-bit stall counter
        out_ready = 2'b00;
        for (int k = 0; k < 4; k++) send(16'(k));
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_stall0", 32'(stall_cnt[0 +: CNT_W]), 32'd15);
        chk("sat_stall1", 32'(stall_cnt[CNT_W +: CNT_W]), 32'd15);
        in_valid = 1'b0;
        exp_q[0].delete(); exp_q[1].delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
